// File: rtl/pc_sequencer.sv
// Program-counter sequencer with jump, increment and an optional return-address stack.
// The stack is built only when PC_SEQUENCER_CALL_STACK_EN is defined; otherwise call acts as load.
module pc_sequencer #(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             load,
    input  logic             inc,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] pc,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             stack_err
);

    logic [WIDTH-1:0] pc_nxt;
    logic [WIDTH-1:0] pc_inc;

    assign pc_inc = pc + 1'b1;

`ifdef PC_SEQUENCER_CALL_STACK_EN
    localparam int PTR_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int DEPTH_W = PTR_W + 1;
    localparam logic [DEPTH_W-1:0] FULL_DEPTH = DEPTH_W'(STACK_DEPTH);

    logic [WIDTH-1:0]   stack_mem [STACK_DEPTH];
    logic [DEPTH_W-1:0] depth;
    logic [DEPTH_W-1:0] depth_nxt;
    logic               err_nxt;
    logic               push;
    logic [PTR_W-1:0]   wr_idx;
    logic [PTR_W-1:0]   rd_idx;
    logic               not_empty;
    logic               not_full;

    // depth doubles as the next free slot; the top entry sits one below it
    assign wr_idx    = depth[PTR_W-1:0];
    assign rd_idx    = wr_idx - 1'b1;
    assign not_empty = (depth != '0);
    assign not_full  = (depth != FULL_DEPTH);

    always_comb begin
        pc_nxt    = pc;
        depth_nxt = depth;
        err_nxt   = stack_err;
        push      = 1'b0;
        if (!stall) begin
            if (ret) begin
                if (not_empty) begin
                    pc_nxt    = stack_mem[rd_idx];
                    depth_nxt = depth - 1'b1;
                end else begin
                    err_nxt = 1'b1;
                end
            end else if (call) begin
                pc_nxt = target;
                if (not_full) begin
                    push      = rst_n;
                    depth_nxt = depth + 1'b1;
                end else begin
                    err_nxt = 1'b1;
                end
            end else if (load) begin
                pc_nxt = target;
            end else if (inc) begin
                pc_nxt = pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= '0;
            depth       <= '0;
            stack_empty <= 1'b1;
            stack_full  <= 1'b0;
            stack_err   <= 1'b0;
        end else begin
            pc          <= pc_nxt;
            depth       <= depth_nxt;
            stack_empty <= (depth_nxt == '0);
            stack_full  <= (depth_nxt == FULL_DEPTH);
            stack_err   <= err_nxt;
        end
    end

    // Entry storage carries no reset; it is never read while depth is zero
    always_ff @(posedge clk) begin
        if (push) begin
            stack_mem[wr_idx] <= pc_inc;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{ret, 1'(STACK_DEPTH)};

    always_comb begin
        pc_nxt = pc;
        if (!stall) begin
            if (call || load) begin
                pc_nxt = target;
            end else if (inc) begin
                pc_nxt = pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= '0;
        end else begin
            pc <= pc_nxt;
        end
    end

    assign stack_empty = 1'b1;
    assign stack_full  = 1'b0;
    assign stack_err   = 1'b0;
`endif

endmodule
